// File: rtl/lib_uart.sv
// Shared UART frame constants and the state encoding used by both the
// transmitter and the receiver.
package lib_uart;

    localparam int DATA_W = 8;  // data bits per frame
    localparam int IDX_W  = 3;  // width of the data-bit index

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } uart_state;

endpackage

// File: rtl/uart_rx.sv
// 8N1 receiver: 2-flop synchronizer, mid-bit sampling FSM and the
// CPU-facing byte register with its ready flag.
//
// state | meaning
// IDLE  | line idle, waiting for a synchronized falling edge
// START | counting half a bit, then re-checking the start bit (glitch filter)
// DATA  | sampling 8 data bits, LSB first, one per bit period
// STOP  | sampling the stop bit; on framing error, waiting for the line to go high
module uart_rx
    import lib_uart::*;
#(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              rxd,
    input  logic              ack,
    output logic              irr,
    output logic [DATA_W-1:0] r_data
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_W - 1);

    logic [1:0]        sync_q;
    logic              rx_prev;
    logic              rx_s;
    logic              fall;
    uart_state         state, state_n;
    logic [CNT_W-1:0]  cnt, cnt_n;
    logic [IDX_W-1:0]  idx, idx_n;
    logic [DATA_W-1:0] shreg, shreg_n;
    logic              ferr, ferr_n;
    logic              done;

    assign rx_s = sync_q[1];
    assign fall = rx_prev & ~rx_s;

    // Synchronizer plus one extra stage for falling-edge detection; all idle high.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync_q  <= 2'b11;
            rx_prev <= 1'b1;
        end else begin
            sync_q  <= {sync_q[0], rxd};
            rx_prev <= rx_s;
        end
    end

    // FSM state register; the down-counter reloads at each sample point.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            cnt   <= '0;
            idx   <= '0;
            shreg <= '0;
            ferr  <= 1'b0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            idx   <= idx_n;
            shreg <= shreg_n;
            ferr  <= ferr_n;
        end
    end

    // Next-state logic; a sample is taken when the down-counter hits zero.
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        idx_n   = idx;
        shreg_n = shreg;
        ferr_n  = ferr;
        done    = 1'b0;
        case (state)
            IDLE: begin
                if (fall) begin
                    state_n = START;
                    cnt_n   = CNT_HALF;
                end
            end
            START: begin
                if (cnt != '0) begin
                    cnt_n = cnt - 1'b1;
                end else if (rx_s) begin
                    state_n = IDLE;
                end else begin
                    state_n = DATA;
                    cnt_n   = CNT_FULL;
                    idx_n   = '0;
                end
            end
            DATA: begin
                if (cnt != '0) begin
                    cnt_n = cnt - 1'b1;
                end else begin
                    shreg_n = {rx_s, shreg[DATA_W-1:1]};
                    cnt_n   = CNT_FULL;
                    if (idx == IDX_LAST) begin
                        state_n = STOP;
                    end else begin
                        idx_n = idx + 1'b1;
                    end
                end
            end
            STOP: begin
                // After a bad stop bit, stay here until the line has been high once.
                if (ferr) begin
                    if (rx_s) begin
                        ferr_n  = 1'b0;
                        state_n = IDLE;
                    end
                end else if (cnt != '0) begin
                    cnt_n = cnt - 1'b1;
                end else if (rx_s) begin
                    done    = 1'b1;
                    state_n = IDLE;
                end else begin
                    ferr_n = 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // CPU byte register; a completing byte wins over a simultaneous ack.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_data <= '0;
            irr    <= 1'b0;
        end else if (done) begin
            r_data <= shreg;
            irr    <= 1'b1;
        end else if (ack) begin
            irr <= 1'b0;
        end
    end

endmodule

// File: rtl/uart_io.sv
// UART with CPU-side byte interface: inline 8N1 transmitter plus the
// uart_rx receiver. TX and RX share nothing but the clock and reset.
//
// state | meaning
// IDLE  | txd high, ready to accept w_req
// START | driving the start bit (0)
// DATA  | shifting out 8 data bits, LSB first
// STOP  | driving the stop bit (1)
module uart_io
    import lib_uart::*;
#(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              rxd,
    output logic              txd,
    output logic              irr,
    input  logic              ack,
    output logic [DATA_W-1:0] r_data,
    input  logic              w_req,
    input  logic [DATA_W-1:0] w_data,
    output logic              w_busy
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_W - 1);

    uart_state         tx_state, tx_state_n;
    logic [CNT_W-1:0]  tx_cnt, tx_cnt_n;
    logic [IDX_W-1:0]  tx_idx, tx_idx_n;
    logic [DATA_W-1:0] tx_shreg, tx_shreg_n;
    logic              txd_n;

    // Busy for exactly the START..STOP span; IDLE is the only accepting state.
    assign w_busy = (tx_state != IDLE);

    // TX state register; txd is a flop so the line is glitch-free.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tx_state <= IDLE;
            tx_cnt   <= '0;
            tx_idx   <= '0;
            tx_shreg <= '0;
            txd      <= 1'b1;
        end else begin
            tx_state <= tx_state_n;
            tx_cnt   <= tx_cnt_n;
            tx_idx   <= tx_idx_n;
            tx_shreg <= tx_shreg_n;
            txd      <= txd_n;
        end
    end

    // TX next-state logic; the next line level is set on each bit boundary.
    always_comb begin
        tx_state_n = tx_state;
        tx_cnt_n   = tx_cnt;
        tx_idx_n   = tx_idx;
        tx_shreg_n = tx_shreg;
        txd_n      = txd;
        case (tx_state)
            IDLE: begin
                txd_n = 1'b1;
                if (w_req) begin
                    tx_state_n = START;
                    tx_shreg_n = w_data;
                    tx_cnt_n   = CNT_FULL;
                    txd_n      = 1'b0;
                end
            end
            START: begin
                if (tx_cnt != '0) begin
                    tx_cnt_n = tx_cnt - 1'b1;
                end else begin
                    tx_state_n = DATA;
                    tx_cnt_n   = CNT_FULL;
                    tx_idx_n   = '0;
                    txd_n      = tx_shreg[0];
                end
            end
            DATA: begin
                if (tx_cnt != '0) begin
                    tx_cnt_n = tx_cnt - 1'b1;
                end else begin
                    tx_cnt_n = CNT_FULL;
                    if (tx_idx == IDX_LAST) begin
                        tx_state_n = STOP;
                        txd_n      = 1'b1;
                    end else begin
                        tx_idx_n   = tx_idx + 1'b1;
                        tx_shreg_n = {1'b0, tx_shreg[DATA_W-1:1]};
                        txd_n      = tx_shreg[1];
                    end
                end
            end
            STOP: begin
                if (tx_cnt != '0) begin
                    tx_cnt_n = tx_cnt - 1'b1;
                end else begin
                    tx_state_n = IDLE;
                end
            end
            default: tx_state_n = IDLE;
        endcase
    end

    uart_rx #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_rx (
        .clk    (clk),
        .reset  (reset),
        .rxd    (rxd),
        .ack    (ack),
        .irr    (irr),
        .r_data (r_data)
    );

endmodule

// File: tb/tb_uart_io.sv
// Self-checking bench for uart_io with CLKS_PER_BIT=16. Inputs are driven and
// outputs sampled on the falling clock edge. Expected TX bytes and RX bytes are
// queued when stimulus is issued and popped when the DUT produces them.
module tb_uart_io;

    localparam int CPB = 16;

    logic       clk     = 1'b0;
    logic       reset   = 1'b0;
    logic       rxd;
    logic       txd;
    logic       irr;
    logic       ack     = 1'b0;
    logic [7:0] r_data;
    logic       w_req   = 1'b0;
    logic [7:0] w_data  = 8'h00;
    logic       w_busy;
    logic       rxd_drv = 1'b1;
    logic       loop_en = 1'b0;

    int errors = 0;
    int checks = 0;

    byte unsigned tx_exp[$];
    byte unsigned tx_got[$];
    byte unsigned rx_exp[$];

    assign rxd = loop_en ? txd : rxd_drv;

    uart_io #(.CLKS_PER_BIT(CPB)) dut (
        .clk    (clk),
        .reset  (reset),
        .rxd    (rxd),
        .txd    (txd),
        .irr    (irr),
        .ack    (ack),
        .r_data (r_data),
        .w_req  (w_req),
        .w_data (w_data),
        .w_busy (w_busy)
    );

    always #5 clk = ~clk;

    // Independent txd decoder: samples each bit at mid-bit, pushes bytes with a good stop bit.
    initial begin : tx_decoder
        logic [7:0] b;
        b = 8'h00;
        forever begin
            @(negedge clk);
            if (reset === 1'b1 && txd === 1'b0) begin
                repeat (CPB / 2) @(negedge clk);
                if (txd === 1'b0) begin
                    for (int i = 0; i < 8; i++) begin
                        repeat (CPB) @(negedge clk);
                        b[i] = txd;
                    end
                    repeat (CPB) @(negedge clk);
                    if (txd === 1'b1) tx_got.push_back(b);
                end
            end
        end
    end

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
        $fatal(1, "timeout");
    end

    task automatic send_rx(input logic [7:0] b, input logic stop, output int rise);
        logic [9:0] f;
        f    = {stop, b, 1'b0};
        rise = -1;
        if (stop) rx_exp.push_back(b);
        for (int i = 0; i < 10; i++) begin
            rxd_drv = f[i];
            for (int c = 0; c < CPB; c++) begin
                @(negedge clk);
                if (i == 9 && rise < 0 && irr === 1'b1) rise = c;
            end
        end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        checks++; if (txd !== 1'b1)     begin errors++; $display("FAIL reset_txd: got %b expected 1", txd); end
        checks++; if (w_busy !== 1'b0)  begin errors++; $display("FAIL reset_w_busy: got %b expected 0", w_busy); end
        checks++; if (irr !== 1'b0)     begin errors++; $display("FAIL reset_irr: got %b expected 0", irr); end
        checks++; if (r_data !== 8'h00) begin errors++; $display("FAIL reset_r_data: got %h expected 00", r_data); end
        reset = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_tx_a5();
        logic [9:0] frame;
        logic       exp_bits[$];
        logic       exp_bit;
        int         bad;
        int         busy_cnt;
        byte unsigned e;
        frame    = {1'b1, 8'hA5, 1'b0};
        exp_bit  = 1'b1;
        bad      = 0;
        busy_cnt = 0;
        for (int i = 0; i < 10; i++) exp_bits.push_back(frame[i]);
        tx_exp.push_back(8'hA5);
        w_data = 8'hA5; w_req = 1'b1;
        @(negedge clk);
        w_req = 1'b0; w_data = 8'h00;
        for (int i = 0; i < 10 * CPB; i++) begin
            if (i % CPB == 0) begin exp_bit = exp_bits.pop_front(); bad = 0; end
            if (txd !== exp_bit) bad++;
            if (w_busy === 1'b1) busy_cnt++;
            if (i % CPB == CPB - 1) begin
                checks++;
                if (bad != 0) begin
                    errors++;
                    $display("FAIL tx_a5_bit%0d: txd wrong in %0d of 16 cycles, expected level %b", i / CPB, bad, exp_bit);
                end
            end
            @(negedge clk);
        end
        checks++; if (busy_cnt != 160) begin errors++; $display("FAIL tx_a5_busy_len: got %0d cycles expected 160", busy_cnt); end
        checks++; if (w_busy !== 1'b0) begin errors++; $display("FAIL tx_a5_busy_end: got %b expected 0", w_busy); end
        checks++; if (txd !== 1'b1)    begin errors++; $display("FAIL tx_a5_idle_txd: got %b expected 1", txd); end
        e = tx_exp.pop_front();
        checks++;
        if (tx_got.size() == 0) begin errors++; $display("FAIL tx_a5_decode: got none expected %h", e); end
        else begin
            byte unsigned g;
            g = tx_got.pop_front();
            if (g !== e) begin errors++; $display("FAIL tx_a5_decode: got %h expected %h", g, e); end
        end
        repeat (4) @(negedge clk);
    endtask

    task automatic test_back_to_back();
        int n;
        byte unsigned e;
        byte unsigned g;
        n = 0;
        tx_exp.push_back(8'h55);
        w_data = 8'h55; w_req = 1'b1;
        @(negedge clk);
        w_req = 1'b0;
        repeat (39) @(negedge clk);
        w_data = 8'hFF; w_req = 1'b1;
        @(negedge clk);
        w_req = 1'b0; w_data = 8'h00;
        while (w_busy === 1'b1 && n < 400) begin @(negedge clk); n++; end
        checks++;
        if (41 + n != 161) begin errors++; $display("FAIL b2b_busy_len: busy ended at cycle %0d expected 161", 41 + n); end
        tx_exp.push_back(8'h0F);
        w_data = 8'h0F; w_req = 1'b1;
        @(negedge clk);
        w_req = 1'b0; w_data = 8'h00;
        checks++; if (txd !== 1'b0)    begin errors++; $display("FAIL b2b_gap_txd: got %b expected 0", txd); end
        checks++; if (w_busy !== 1'b1) begin errors++; $display("FAIL b2b_gap_busy: got %b expected 1", w_busy); end
        n = 0;
        while (w_busy === 1'b1 && n < 400) begin @(negedge clk); n++; end
        checks++; if (n >= 400) begin errors++; $display("FAIL b2b_timeout: busy stuck, got %0d cycles expected < 400", n); end
        repeat (4) @(negedge clk);
        while (tx_exp.size() > 0) begin
            e = tx_exp.pop_front();
            checks++;
            if (tx_got.size() == 0) begin errors++; $display("FAIL b2b_decode: got none expected %h", e); end
            else begin
                g = tx_got.pop_front();
                if (g !== e) begin errors++; $display("FAIL b2b_decode: got %h expected %h", g, e); end
            end
        end
        checks++; if (tx_got.size() != 0) begin errors++; $display("FAIL b2b_extra: got %0d extra frames expected 0", tx_got.size()); end
    endtask

    task automatic test_rx_basic();
        int rise;
        byte unsigned e;
        checks++; if (irr !== 1'b0) begin errors++; $display("FAIL rx_pre_irr: got %b expected 0", irr); end
        send_rx(8'h3C, 1'b1, rise);
        checks++;
        if (rise < 7 || rise > 13) begin errors++; $display("FAIL rx_irr_timing: irr rose at stop cycle %0d expected 7..13", rise); end
        e = rx_exp.pop_front();
        checks++; if (r_data !== e)  begin errors++; $display("FAIL rx_3c_data: got %h expected %h", r_data, e); end
        checks++; if (irr !== 1'b1)  begin errors++; $display("FAIL rx_3c_irr: got %b expected 1", irr); end
        ack = 1'b1;
        @(negedge clk);
        checks++; if (irr !== 1'b0)  begin errors++; $display("FAIL rx_ack_clear: got %b expected 0", irr); end
        repeat (3) @(negedge clk);
        ack = 1'b0;
        repeat (2) @(negedge clk);
        checks++; if (irr !== 1'b0)  begin errors++; $display("FAIL rx_ack_stay: got %b expected 0", irr); end
    endtask

    task automatic test_rx_overrun();
        int rise;
        byte unsigned e;
        send_rx(8'h11, 1'b1, rise);
        e = rx_exp.pop_front();
        checks++; if (r_data !== e) begin errors++; $display("FAIL ovr_11_data: got %h expected %h", r_data, e); end
        send_rx(8'h22, 1'b1, rise);
        e = rx_exp.pop_front();
        checks++; if (r_data !== e) begin errors++; $display("FAIL ovr_22_data: got %h expected %h", r_data, e); end
        checks++; if (irr !== 1'b1) begin errors++; $display("FAIL ovr_irr: got %b expected 1", irr); end
        ack = 1'b1; @(negedge clk); ack = 1'b0; @(negedge clk);
    endtask

    task automatic test_glitch();
        rxd_drv = 1'b0;
        repeat (5) @(negedge clk);
        rxd_drv = 1'b1;
        repeat (200) @(negedge clk);
        checks++; if (irr !== 1'b0)     begin errors++; $display("FAIL glitch_irr: got %b expected 0", irr); end
        checks++; if (r_data !== 8'h22) begin errors++; $display("FAIL glitch_data: got %h expected 22", r_data); end
    endtask

    task automatic test_framing();
        int rise;
        byte unsigned e;
        send_rx(8'h5A, 1'b0, rise);
        repeat (20) @(negedge clk);
        checks++; if (irr !== 1'b0)     begin errors++; $display("FAIL frm_irr: got %b expected 0", irr); end
        checks++; if (r_data !== 8'h22) begin errors++; $display("FAIL frm_data: got %h expected 22", r_data); end
        rxd_drv = 1'b1;
        repeat (5) @(negedge clk);
        send_rx(8'h96, 1'b1, rise);
        e = rx_exp.pop_front();
        checks++; if (r_data !== e)  begin errors++; $display("FAIL frm_recover_data: got %h expected %h", r_data, e); end
        checks++; if (irr !== 1'b1)  begin errors++; $display("FAIL frm_recover_irr: got %b expected 1", irr); end
        ack = 1'b1; @(negedge clk); ack = 1'b0; @(negedge clk);
    endtask

    task automatic test_loopback();
        int n;
        byte unsigned e;
        byte unsigned g;
        n = 0;
        loop_en = 1'b1;
        tx_exp.push_back(8'hC3);
        rx_exp.push_back(8'hC3);
        w_data = 8'hC3; w_req = 1'b1;
        @(negedge clk);
        w_req = 1'b0; w_data = 8'h00;
        while (w_busy === 1'b1 && n < 400) begin @(negedge clk); n++; end
        repeat (20) @(negedge clk);
        loop_en = 1'b0;
        e = rx_exp.pop_front();
        checks++; if (r_data !== e) begin errors++; $display("FAIL loop_rx_data: got %h expected %h", r_data, e); end
        checks++; if (irr !== 1'b1) begin errors++; $display("FAIL loop_irr: got %b expected 1", irr); end
        e = tx_exp.pop_front();
        checks++;
        if (tx_got.size() == 0) begin errors++; $display("FAIL loop_tx_decode: got none expected %h", e); end
        else begin
            g = tx_got.pop_front();
            if (g !== e) begin errors++; $display("FAIL loop_tx_decode: got %h expected %h", g, e); end
        end
        ack = 1'b1; @(negedge clk); ack = 1'b0; @(negedge clk);
    endtask

    task automatic test_reset_mid();
        w_data = 8'h81; w_req = 1'b1;
        rxd_drv = 1'b0;
        @(negedge clk);
        w_req = 1'b0; w_data = 8'h00;
        repeat (50) @(negedge clk);
        reset = 1'b0;
        rxd_drv = 1'b1;
        #1;
        checks++; if (txd !== 1'b1)     begin errors++; $display("FAIL rst_mid_txd: got %b expected 1", txd); end
        checks++; if (w_busy !== 1'b0)  begin errors++; $display("FAIL rst_mid_busy: got %b expected 0", w_busy); end
        checks++; if (r_data !== 8'h00) begin errors++; $display("FAIL rst_mid_data: got %h expected 00", r_data); end
        repeat (3) @(negedge clk);
        reset = 1'b1;
        repeat (200) @(negedge clk);
        checks++; if (irr !== 1'b0)     begin errors++; $display("FAIL rst_after_irr: got %b expected 0", irr); end
        checks++; if (w_busy !== 1'b0)  begin errors++; $display("FAIL rst_after_busy: got %b expected 0", w_busy); end
        checks++; if (txd !== 1'b1)     begin errors++; $display("FAIL rst_after_txd: got %b expected 1", txd); end
    endtask

    initial begin
        test_reset();
        test_tx_a5();
        test_back_to_back();
        test_rx_basic();
        test_rx_overrun();
        test_glitch();
        test_framing();
        test_loopback();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
